// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the Decode-stage register file.
package regfile_pkg;

  localparam int DW_DEF     = 32;
  localparam int NREG_DEF   = 16;
  localparam int NR_DEF     = 3;
  localparam int NW_DEF     = 2;
  localparam int PC_IDX_DEF = 15;

  // Address width for a file of n registers; never narrower than one bit.
  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int AW_DEF = addr_width(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_fwd_mux.sv
// One read port: PC select, write-first forwarding and busy generation.
module rf_fwd_mux
  import regfile_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NW     = NW_DEF,
  parameter int PC_IDX = PC_IDX_DEF,
  localparam int AW    = addr_width(NREG)
) (
  input  logic                     reset_i,
  input  logic [AW-1:0]            rd_addr_i,
  input  logic [DW-1:0]            pc_in_i,
  input  logic [NW-1:0]            wr_en_i,
  input  logic [NW-1:0][AW-1:0]    wr_addr_i,
  input  logic [NW-1:0][DW-1:0]    wr_data_i,
  input  logic [NREG-1:0][DW-1:0]  mem_i,
  input  logic [NREG-1:0]          pend_i,
  output logic [DW-1:0]            rd_data_o,
  output logic                     rd_busy_o
);

  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic          in_range;

  assign in_range = ({1'b0, rd_addr_i} < (AW+1)'(NREG));

  // Highest-index matching write port supplies forwarded data; reset kills forwarding.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int j = 0; j < NW; j++) begin
      if (!reset_i && wr_en_i[j] && (wr_addr_i[j] == rd_addr_i)) begin
        fwd_hit  = 1'b1;
        fwd_data = wr_data_i[j];
      end
    end
  end

  // Priority: PC, then out-of-range (reads zero), then forwarded write, then stored entry.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = 1'b0;
    if (rd_addr_i == AW'(PC_IDX)) begin
      rd_data_o = pc_in_i;
    end else if (!in_range) begin
      rd_data_o = '0;
    end else if (fwd_hit) begin
      rd_data_o = fwd_data;
    end else begin
      rd_data_o = mem_i[rd_addr_i];
      rd_busy_o = pend_i[rd_addr_i];
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with per-register pending bits for the hazard unit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NR     = NR_DEF,
  parameter int NW     = NW_DEF,
  parameter int PC_IDX = PC_IDX_DEF,
  localparam int AW    = addr_width(NREG)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR-1:0][AW-1:0]  rd_addr,
  output logic [NR-1:0][DW-1:0]  rd_data,
  output logic [NR-1:0]          rd_busy,
  input  logic [DW-1:0]          pc_in,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW-1:0][AW-1:0]  wr_addr,
  input  logic [NW-1:0][DW-1:0]  wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic [AW:0]            pend_cnt
);

  logic [NREG-1:0][DW-1:0] mem_q, mem_d;
  logic [NREG-1:0]         pend_q, pend_d;
  logic [NREG-1:0]         wr_hit, iss_hit;
  logic [AW:0]             cnt_q, cnt_d;

  // Decode which registers are written back and which one is being issued; PC never matches.
  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int r = 0; r < NREG; r++) begin
      if (r != PC_IDX) begin
        iss_hit[r] = iss_en && (iss_addr == AW'(r));
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && (wr_addr[j] == AW'(r))) begin
            wr_hit[r] = 1'b1;
          end
        end
      end
    end
  end

  // Next storage and pending state; ascending port loop lets the higher port win, issue beats retire.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int r = 0; r < NREG; r++) begin
      if (r != PC_IDX) begin
        for (int j = 0; j < NW; j++) begin
          if (wr_en[j] && (wr_addr[j] == AW'(r))) begin
            mem_d[r] = wr_data[j];
          end
        end
        pend_d[r] = iss_hit[r] | (pend_q[r] & ~wr_hit[r]);
      end
    end
  end

  // Popcount of the next pending vector so the counter tracks the bits on the same edge.
  always_comb begin
    cnt_d = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + (AW+1)'(pend_d[r]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q  <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    rf_fwd_mux #(
      .DW     (DW),
      .NREG   (NREG),
      .NW     (NW),
      .PC_IDX (PC_IDX)
    ) u_mux (
      .reset_i   (reset),
      .rd_addr_i (rd_addr[i]),
      .pc_in_i   (pc_in),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .mem_i     (mem_q),
      .pend_i    (pend_q),
      .rd_data_o (rd_data[i]),
      .rd_busy_o (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: stimulus queues expected port values, a negedge monitor checks them.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;
  localparam int AW = AW_DEF;

  logic                  clk;
  logic                  reset;
  logic [NR-1:0][AW-1:0] rd_addr;
  logic [NR-1:0][DW-1:0] rd_data;
  logic [NR-1:0]         rd_busy;
  logic [DW-1:0]         pc_in;
  logic [NW-1:0]         wr_en;
  logic [NW-1:0][AW-1:0] wr_addr;
  logic [NW-1:0][DW-1:0] wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic [AW:0]           pend_cnt;

  regfile_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .pc_in    (pc_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 pend_cnt
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: every negedge, drain the expectations queued for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = rd_data[e.port];
        1:       act = {31'b0, rd_busy[e.port]};
        default: act = 32'(pend_cnt);
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic exp_rd(input string nm, input int p, input logic [31:0] d, input logic b);
    exp_t e;
    e.name = {nm, "_data"}; e.kind = 0; e.port = p; e.exp = d;
    exp_q.push_back(e);
    e.name = {nm, "_busy"}; e.kind = 1; e.port = p; e.exp = {31'b0, b};
    exp_q.push_back(e);
  endtask

  task automatic exp_cnt(input string nm, input int v);
    exp_t e;
    e.name = nm; e.kind = 2; e.port = 0; e.exp = 32'(v);
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input logic [31:0] d);
    wr_en[p]   = 1'b1;
    wr_addr[p] = AW'(a);
    wr_data[p] = d;
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    pc_in   = 32'h0000_0108;
    idle();
    step();
    step();
    reset = 1'b0;

    // 1: reset state
    rd_addr[0] = AW'(3); rd_addr[1] = AW'(15); rd_addr[2] = AW'(0);
    exp_rd("rst_r3", 0, 32'h0, 1'b0);
    exp_rd("rst_pc", 1, 32'h0000_0108, 1'b0);
    exp_cnt("rst_cnt", 0);
    step();

    // 2: write R4 with same-cycle forward, then stored read
    wr(0, 4, 32'hDEAD_BEEF);
    rd_addr[1] = AW'(4);
    exp_rd("fwd_r4", 1, 32'hDEAD_BEEF, 1'b0);
    step();
    idle();
    rd_addr[0] = AW'(4);
    exp_rd("st_r4_p0", 0, 32'hDEAD_BEEF, 1'b0);
    exp_rd("st_r4_p1", 1, 32'hDEAD_BEEF, 1'b0);
    step();

    // 3: both ports write R7, higher port wins
    wr(0, 7, 32'h11);
    wr(1, 7, 32'h22);
    rd_addr[2] = AW'(7);
    exp_rd("dual_fwd_r7", 2, 32'h22, 1'b0);
    step();
    idle();
    exp_rd("dual_st_r7", 2, 32'h22, 1'b0);
    step();

    // 4: issue R5, then retire it
    iss(5);
    rd_addr[0] = AW'(5);
    exp_rd("iss_r5_now", 0, 32'h0, 1'b0);
    exp_cnt("iss_cnt_now", 0);
    step();
    idle();
    exp_rd("iss_r5_busy", 0, 32'h0, 1'b1);
    exp_cnt("iss_cnt1", 1);
    step();
    wr(0, 5, 32'h55);
    exp_rd("wb_r5_fwd", 0, 32'h55, 1'b0);
    exp_cnt("wb_cnt_before", 1);
    step();
    idle();
    exp_rd("wb_r5_st", 0, 32'h55, 1'b0);
    exp_cnt("wb_cnt_after", 0);
    step();

    // 5: issue and retire R5 on the same edge; issue wins
    iss(5);
    step();
    idle();
    exp_cnt("re_iss_cnt", 1);
    step();
    iss(5);
    wr(1, 5, 32'h66);
    exp_rd("same_fwd_r5", 0, 32'h66, 1'b0);
    exp_cnt("same_cnt_before", 1);
    step();
    idle();
    exp_rd("same_st_r5", 0, 32'h66, 1'b1);
    exp_cnt("same_cnt_after", 1);
    step();
    wr(0, 5, 32'h77);
    wr(1, 9, 32'h99);   // R9 was never pending: clearing a clear bit
    step();
    idle();
    rd_addr[1] = AW'(9);
    exp_rd("clr_r5", 0, 32'h77, 1'b0);
    exp_rd("clr_r9", 1, 32'h99, 1'b0);
    exp_cnt("clr_cnt", 0);
    step();

    // 6: several pending, then reset with a write in flight
    iss(1); step();
    iss(2); step();
    iss(3); step();
    idle();
    rd_addr[0] = AW'(1); rd_addr[1] = AW'(2); rd_addr[2] = AW'(3);
    exp_rd("pend_r1", 0, 32'h0, 1'b1);
    exp_rd("pend_r2", 1, 32'h0, 1'b1);
    exp_rd("pend_r3", 2, 32'h0, 1'b1);
    exp_cnt("pend_cnt3", 3);
    step();
    reset = 1'b1;
    wr(0, 1, 32'h99);
    iss(6);
    exp_rd("rst_nofwd_r1", 0, 32'h0, 1'b1);
    step();
    reset = 1'b0;
    idle();
    rd_addr[1] = AW'(4);
    exp_rd("post_rst_r1", 0, 32'h0, 1'b0);
    exp_rd("post_rst_r4", 1, 32'h0, 1'b0);
    exp_cnt("post_rst_cnt", 0);
    step();

    // PC writes and issues are ignored by the file
    pc_in = 32'h0000_0200;
    wr(0, 15, 32'h0000_0BAD);
    wr(1, 8, 32'h88);
    iss(15);
    rd_addr[0] = AW'(15); rd_addr[1] = AW'(8);
    exp_rd("pcw_rd_pc", 0, 32'h0000_0200, 1'b0);
    exp_rd("pcw_fwd_r8", 1, 32'h88, 1'b0);
    step();
    idle();
    rd_addr[2] = AW'(0);
    exp_rd("pc_rd_after", 0, 32'h0000_0200, 1'b0);
    exp_rd("r8_st", 1, 32'h88, 1'b0);
    exp_rd("r0_st", 2, 32'h0, 1'b0);
    exp_cnt("pc_iss_cnt", 0);
    step();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
